// File: rtl/regfile_port_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_port_arbiter
//
// Shares one 32x32 register file (two clocked read ports, one write port)
// between two requesters: side 0 (CPU writeback/decode) and side 1
// (debug/load unit). One side is granted per cycle. The granted side's
// addresses and write data are steered onto the register file, and the read
// data comes back one cycle later, qualified by a per-side valid strobe.
// A side can hold ownership across several cycles with lockN, which makes
// read-modify-write sequences atomic. Writes to r0 are dropped, and reads of
// r0 return zero.
//
// Ports
//   clk, reset            rising-edge clock; synchronous active-high reset
//   reqN, lockN, weN      request / hold ownership / write enable (N = 0, 1)
//   aaN, abN, waddrN      read address A, read address B, write address
//   wdataN                write data
//   gntN                  combinational grant for this cycle
//   rvalidN               registered: rdata_a/b belong to side N this cycle
//   rdata_a, rdata_b      shared read data bus (zero when no rvalid)
//   rf_wren, rf_aw, rf_dw register file write port
//   rf_aa, rf_ab          register file read addresses
//   rf_da, rf_db          register file read data (one cycle after rf_aa/ab)
// ---------------------------------------------------------------------------
module regfile_port_arbiter #(
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              lock0,
    input  logic              we0,
    input  logic [AWIDTH-1:0] aa0,
    input  logic [AWIDTH-1:0] ab0,
    input  logic [AWIDTH-1:0] waddr0,
    input  logic [WIDTH-1:0]  wdata0,
    input  logic              req1,
    input  logic              lock1,
    input  logic              we1,
    input  logic [AWIDTH-1:0] aa1,
    input  logic [AWIDTH-1:0] ab1,
    input  logic [AWIDTH-1:0] waddr1,
    input  logic [WIDTH-1:0]  wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              rf_wren,
    output logic [AWIDTH-1:0] rf_aw,
    output logic [AWIDTH-1:0] rf_aa,
    output logic [AWIDTH-1:0] rf_ab,
    output logic [WIDTH-1:0]  rf_dw,
    input  logic [WIDTH-1:0]  rf_da,
    input  logic [WIDTH-1:0]  rf_db
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   rr_ptr_q, rr_ptr_d;   // 0: side 0 wins the next contention

    // Last granted addresses/data, held on the register file while idle.
    logic [AWIDTH-1:0] aa_q, ab_q, aw_q;
    logic [WIDTH-1:0]  dw_q;

    logic rvalid0_q, rvalid1_q;
    // Remembers that the read now returning was of r0, so it can be zeroed
    // regardless of what the register file holds there.
    logic rd_a_zero_q, rd_b_zero_q;

    logic              granted;
    logic              sel_we;
    logic [AWIDTH-1:0] sel_aa, sel_ab, sel_aw;
    logic [WIDTH-1:0]  sel_dw;

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state is always assigned with <=, so every flop
    // samples the pre-edge values of its neighbours and the order of the
    // statements does not matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next state and round-robin pointer
    // ------------------------------------------------------------------
    // NOTE: every variable written here gets a default on entry, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                // The pointer moves only when there was a real contention.
                if (req0 && req1) begin
                    rr_ptr_d = ~rr_ptr_q;
                end
                if (gnt0 && lock0) begin
                    state_d = OWN0;
                end else if (gnt1 && lock1) begin
                    state_d = OWN1;
                end
            end
            // Ownership ends on the cycle the owner drops its lock, even when
            // it is not requesting that cycle.
            OWN0:    if (!lock0) state_d = IDLE;
            OWN1:    if (!lock1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: grants
    // ------------------------------------------------------------------
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (req0 && req1) begin
                        gnt0 = ~rr_ptr_q;
                        gnt1 = rr_ptr_q;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                OWN0:    gnt0 = req0;
                OWN1:    gnt1 = req1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file steering
    // ------------------------------------------------------------------
    assign granted = gnt0 | gnt1;
    assign sel_we  = gnt1 ? we1    : we0;
    assign sel_aa  = gnt1 ? aa1    : aa0;
    assign sel_ab  = gnt1 ? ab1    : ab0;
    assign sel_aw  = gnt1 ? waddr1 : waddr0;
    assign sel_dw  = gnt1 ? wdata1 : wdata0;

    always_comb begin
        rf_wren = 1'b0;
        rf_aa   = aa_q;
        rf_ab   = ab_q;
        rf_aw   = aw_q;
        rf_dw   = dw_q;
        if (reset) begin
            rf_aa = '0;
            rf_ab = '0;
            rf_aw = '0;
            rf_dw = '0;
        end else if (granted) begin
            rf_aa   = sel_aa;
            rf_ab   = sel_ab;
            rf_aw   = sel_aw;
            rf_dw   = sel_dw;
            rf_wren = sel_we && (sel_aw != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aa_q <= '0;
            ab_q <= '0;
            aw_q <= '0;
            dw_q <= '0;
        end else if (granted) begin
            aa_q <= sel_aa;
            ab_q <= sel_ab;
            aw_q <= sel_aw;
            dw_q <= sel_dw;
        end
    end

    // ------------------------------------------------------------------
    // Read return path. Grants are already forced low during reset, so a
    // valid that would have followed a mid-lock reset never appears.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rd_a_zero_q <= 1'b0;
            rd_b_zero_q <= 1'b0;
        end else begin
            rvalid0_q   <= gnt0;
            rvalid1_q   <= gnt1;
            rd_a_zero_q <= (rf_aa == '0);
            rd_b_zero_q <= (rf_ab == '0);
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    // Pass-through of the register file outputs, zeroed when nothing is valid
    // or when the returning read was of r0.
    assign rdata_a = ((rvalid0_q || rvalid1_q) && !rd_a_zero_q) ? rf_da : '0;
    assign rdata_b = ((rvalid0_q || rvalid1_q) && !rd_b_zero_q) ? rf_db : '0;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_port_arbiter
//
// Directed bench for regfile_port_arbiter. A behavioural 32x32 register file
// with clocked reads and a nonblocking write sits on the rf_* port. r0 of that
// model holds a non-zero pattern so the arbiter's own r0 zeroing is visible.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// sampled 1 unit later, registered outputs right after the edge.
// ---------------------------------------------------------------------------
module tb_regfile_port_arbiter;

    localparam int WIDTH  = 32;
    localparam int AWIDTH = 5;

    logic              clk;
    logic              reset;
    logic              req0, lock0, we0, req1, lock1, we1;
    logic [AWIDTH-1:0] aa0, ab0, waddr0, aa1, ab1, waddr1;
    logic [WIDTH-1:0]  wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [WIDTH-1:0]  rdata_a, rdata_b;
    logic              rf_wren;
    logic [AWIDTH-1:0] rf_aw, rf_aa, rf_ab;
    logic [WIDTH-1:0]  rf_dw, rf_da, rf_db;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_port_arbiter #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .lock0(lock0), .we0(we0), .aa0(aa0), .ab0(ab0),
        .waddr0(waddr0), .wdata0(wdata0),
        .req1(req1), .lock1(lock1), .we1(we1), .aa1(aa1), .ab1(ab1),
        .waddr1(waddr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .rf_wren(rf_wren), .rf_aw(rf_aw), .rf_aa(rf_aa), .rf_ab(rf_ab),
        .rf_dw(rf_dw), .rf_da(rf_da), .rf_db(rf_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: clocked reads, write lands at the same edge.
    logic [WIDTH-1:0] mem [0:31];
    logic             mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= (i == 0) ? 32'hBAD0_BAD0 : '0;
            mem_init <= 1'b1;
        end else if (rf_wren) begin
            mem[rf_aw] <= rf_dw;
        end
        rf_da <= mem[rf_aa];
        rf_db <= mem[rf_ab];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; lock0 = 0; we0 = 0; aa0 = '0; ab0 = '0; waddr0 = '0; wdata0 = '0;
        req1 = 0; lock1 = 0; we1 = 0; aa1 = '0; ab1 = '0; waddr1 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reset held two cycles with both sides requesting.
    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        req0 = 1; req1 = 1; we0 = 1; waddr0 = 5'd3; wdata0 = 32'h5555_5555; aa0 = 5'd3;
        #1;
        n_checks++; if (gnt0 !== 1'b0) $display("FAIL reset_gnt0: got %b want 0", gnt0); else n_pass++;
        n_checks++; if (gnt1 !== 1'b0) $display("FAIL reset_gnt1: got %b want 0", gnt1); else n_pass++;
        n_checks++; if (rf_wren !== 1'b0) $display("FAIL reset_wren: got %b want 0", rf_wren); else n_pass++;
        n_checks++; if (rf_aw !== 5'd0 || rf_aa !== 5'd0 || rf_dw !== 32'd0)
            $display("FAIL reset_rf_outs: aw=%0d aa=%0d dw=%h want 0", rf_aw, rf_aa, rf_dw); else n_pass++;
        tick();
        tick();
        n_checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0)
            $display("FAIL reset_rvalid: got %b%b want 00", rvalid0, rvalid1); else n_pass++;
        n_checks++; if (rdata_a !== 32'd0 || rdata_b !== 32'd0)
            $display("FAIL reset_rdata: a=%h b=%h want 0", rdata_a, rdata_b); else n_pass++;
        reset = 1'b0;
        clear_inputs();
    endtask

    // Write r5 from side 0, read it back from side 1 the next cycle.
    task automatic test_write_then_read();
        req0 = 1; we0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0)
            $display("FAIL wr_gnt: got %b%b want 10", gnt0, gnt1); else n_pass++;
        n_checks++; if (rf_wren !== 1'b1 || rf_aw !== 5'd5 || rf_dw !== 32'hDEAD_BEEF)
            $display("FAIL wr_port: wren=%b aw=%0d dw=%h want 1/5/deadbeef", rf_wren, rf_aw, rf_dw); else n_pass++;
        tick();
        clear_inputs();
        req1 = 1; aa1 = 5'd5; ab1 = 5'd0;
        #1;
        n_checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0)
            $display("FAIL rd_gnt: got %b%b want 01", gnt0, gnt1); else n_pass++;
        n_checks++; if (rf_aa !== 5'd5 || rf_wren !== 1'b0)
            $display("FAIL rd_port: aa=%0d wren=%b want 5/0", rf_aa, rf_wren); else n_pass++;
        tick();
        clear_inputs();
        n_checks++; if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0)
            $display("FAIL rd_rvalid: got %b%b want 01", rvalid0, rvalid1); else n_pass++;
        n_checks++; if (rdata_a !== 32'hDEAD_BEEF)
            $display("FAIL rd_data_a: got %h want deadbeef", rdata_a); else n_pass++;
        n_checks++; if (rdata_b !== 32'd0)
            $display("FAIL rd_data_b_r0: got %h want 0", rdata_b); else n_pass++;
        // Idle cycle: rf addresses hold the last granted values.
        #1;
        n_checks++; if (rf_aa !== 5'd5 || rf_aw !== 5'd0 || rf_wren !== 1'b0)
            $display("FAIL hold_rf: aa=%0d aw=%0d wren=%b want 5/0/0", rf_aa, rf_aw, rf_wren); else n_pass++;
        tick();
        n_checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0)
            $display("FAIL idle_rvalid: got %b%b want 00", rvalid0, rvalid1); else n_pass++;
    endtask

    // Continuous contention without lock: strict alternation starting at side 0.
    task automatic test_round_robin();
        logic exp0, prev0;
        do_reset();
        prev0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req0 = 1; req1 = 1; aa0 = 5'd5; aa1 = 5'd0;
            exp0 = (i % 2 == 0);
            #1;
            n_checks++; if (gnt0 !== exp0 || gnt1 !== !exp0)
                $display("FAIL rr_gnt[%0d]: got %b%b want %b%b", i, gnt0, gnt1, exp0, !exp0); else n_pass++;
            if (i > 0) begin
                n_checks++; if (rvalid0 !== prev0 || rvalid1 !== !prev0)
                    $display("FAIL rr_rvalid[%0d]: got %b%b want %b%b", i, rvalid0, rvalid1, prev0, !prev0); else n_pass++;
                n_checks++; if (rdata_a !== (prev0 ? 32'hDEAD_BEEF : 32'd0))
                    $display("FAIL rr_rdata[%0d]: got %h want %h", i, rdata_a, prev0 ? 32'hDEAD_BEEF : 32'd0); else n_pass++;
            end
            prev0 = exp0;
            tick();
        end
        clear_inputs();
    endtask

    // Locked read-modify-write of r7 by side 1 while side 0 keeps requesting.
    task automatic test_lock_rmw();
        logic [WIDTH-1:0] r7_seen;
        do_reset();
        req0 = 1; we0 = 1; waddr0 = 5'd7; wdata0 = 32'h0000_0100;
        tick();
        // Contention without lock: side 0 wins, pointer now favours side 1.
        clear_inputs(); req0 = 1; req1 = 1;
        #1;
        n_checks++; if (gnt0 !== 1'b1) $display("FAIL lk_pre_gnt0: got %b want 1", gnt0); else n_pass++;
        tick();
        // c1: side 1 reads r7 and takes the lock.
        lock1 = 1; aa1 = 5'd7;
        #1;
        n_checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0)
            $display("FAIL lk_c1_gnt: got %b%b want 01", gnt0, gnt1); else n_pass++;
        tick();
        // c2: owner idle but still locked; side 0 stays locked out.
        r7_seen = rdata_a;
        n_checks++; if (rvalid1 !== 1'b1 || rdata_a !== 32'h0000_0100)
            $display("FAIL lk_read: rvalid1=%b data=%h want 1/00000100", rvalid1, rdata_a); else n_pass++;
        req1 = 0;
        #1;
        n_checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0)
            $display("FAIL lk_c2_gnt: got %b%b want 00", gnt0, gnt1); else n_pass++;
        tick();
        // c3: owner writes r7 = r7 + 1, still locked.
        req1 = 1; we1 = 1; waddr1 = 5'd7; wdata1 = r7_seen + 32'd1;
        #1;
        n_checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || rf_wren !== 1'b1 || rf_aw !== 5'd7)
            $display("FAIL lk_c3: gnt=%b%b wren=%b aw=%0d want 01/1/7", gnt0, gnt1, rf_wren, rf_aw); else n_pass++;
        tick();
        // c4: lock drops with no request; side 0 still waits this cycle.
        req1 = 0; lock1 = 0; we1 = 0;
        #1;
        n_checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || rf_wren !== 1'b0)
            $display("FAIL lk_c4: gnt=%b%b wren=%b want 00/0", gnt0, gnt1, rf_wren); else n_pass++;
        tick();
        // c5: side 0 granted, reads r7 back.
        aa0 = 5'd7;
        #1;
        n_checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0)
            $display("FAIL lk_c5_gnt: got %b%b want 10", gnt0, gnt1); else n_pass++;
        tick();
        n_checks++; if (rvalid0 !== 1'b1 || rdata_a !== 32'h0000_0101)
            $display("FAIL lk_r7_final: rvalid0=%b data=%h want 1/00000101", rvalid0, rdata_a); else n_pass++;
        clear_inputs();
    endtask

    // Writes to r0 are dropped; r0 reads as zero.
    task automatic test_r0_write();
        req0 = 1; we0 = 1; waddr0 = 5'd0; wdata0 = 32'h0000_1234; aa0 = 5'd0;
        #1;
        n_checks++; if (gnt0 !== 1'b1 || rf_wren !== 1'b0)
            $display("FAIL r0_wren: gnt0=%b wren=%b want 1/0", gnt0, rf_wren); else n_pass++;
        tick();
        we0 = 0;
        tick();
        n_checks++; if (rvalid0 !== 1'b1 || rdata_a !== 32'd0)
            $display("FAIL r0_read: rvalid0=%b data=%h want 1/0", rvalid0, rdata_a); else n_pass++;
        clear_inputs();
    endtask

    // Same-cycle write+read returns the old value; reset drops a held lock.
    task automatic test_back_to_back();
        req0 = 1; we0 = 1; waddr0 = 5'd9; wdata0 = 32'h0000_0011;
        tick();
        req0 = 1; we0 = 1; waddr0 = 5'd9; wdata0 = 32'hA5A5_A5A5; aa0 = 5'd9;
        tick();
        we0 = 0;
        n_checks++; if (rdata_a !== 32'h0000_0011)
            $display("FAIL raw_old: got %h want 00000011", rdata_a); else n_pass++;
        tick();
        n_checks++; if (rdata_a !== 32'hA5A5_A5A5)
            $display("FAIL raw_new: got %h want a5a5a5a5", rdata_a); else n_pass++;
        clear_inputs();
        // Side 1 takes a lock on a cycle where side 0 is idle.
        req1 = 1; lock1 = 1; aa1 = 5'd9;
        #1;
        n_checks++; if (gnt1 !== 1'b1) $display("FAIL own1_gnt: got %b want 1", gnt1); else n_pass++;
        tick();
        req0 = 1;
        reset = 1'b1;
        #1;
        n_checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0)
            $display("FAIL own1_rst_gnt: got %b%b want 00", gnt0, gnt1); else n_pass++;
        tick();
        reset = 1'b0;
        n_checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0)
            $display("FAIL own1_rst_rvalid: got %b%b want 00", rvalid0, rvalid1); else n_pass++;
        // Back in IDLE with pointer at side 0: side 0 wins despite lock1.
        lock1 = 0;
        #1;
        n_checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0)
            $display("FAIL own1_rst_idle: got %b%b want 10", gnt0, gnt1); else n_pass++;
        tick();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_write_then_read();
        test_round_robin();
        test_lock_rmw();
        test_r0_write();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
